// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and types; this slice carries the boot loader's
// state encoding and framing constants alongside the instruction SRAM geometry.
package cpu_pkg;

  localparam int INST_ADDR_WIDTH    = 10;
  localparam int INST_DATA_WIDTH    = 32;
  localparam int LDR_BYTES_PER_WORD = 4;
  localparam int LDR_LEN_W          = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } ldr_state_e;

endpackage

// File: rtl/inst_loader_if.sv
// Byte-stream handshake in, instruction-SRAM write port out. The loader sits
// on the slave side; the byte source / SRAM observer uses master.
interface inst_loader_if #(
  parameter int INST_ADDR_WIDTH = cpu_pkg::INST_ADDR_WIDTH,
  parameter int INST_DATA_WIDTH = cpu_pkg::INST_DATA_WIDTH
);
  logic                       in_valid;
  logic [7:0]                 in_data;
  logic                       in_ready;
  logic                       inst_sram_wr;
  logic [INST_ADDR_WIDTH-1:0] inst_sram_addr;
  logic [INST_DATA_WIDTH-1:0] inst_sram_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, inst_sram_wr, inst_sram_addr, inst_sram_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, inst_sram_wr, inst_sram_addr, inst_sram_data
  );
endinterface

// File: rtl/inst_loader.sv
// Boot-time program loader: parses [len_lo len_hi {4 bytes LE}*len xor_csum]
// and writes each word into instruction SRAM from address 0, holding the core until done.
module inst_loader
  import cpu_pkg::*;
#(
  parameter int INST_ADDR_WIDTH = cpu_pkg::INST_ADDR_WIDTH,
  parameter int INST_DATA_WIDTH = cpu_pkg::INST_DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  inst_loader_if.slave         bus,
  output logic [LDR_LEN_W-1:0] words_loaded,
  output logic                 load_done,
  output logic                 load_err,
  output logic                 core_hold
);

  localparam int IDX_W = $clog2(LDR_BYTES_PER_WORD);

  ldr_state_e                 state;
  logic [LDR_LEN_W-1:0]       count;
  logic [IDX_W-1:0]           byteIdx;
  logic [7:0]                 csum;
  logic [INST_ADDR_WIDTH-1:0] addr;
  logic [INST_DATA_WIDTH-1:0] word;
  logic                       wrStrobe;
  logic                       accept;
  logic [LDR_LEN_W:0]         lenNext;
  logic                       lenBad;

  assign bus.in_ready = (state == LEN_LO) || (state == LEN_HI) ||
                        (state == DATA)   || (state == CSUM);
  assign accept       = bus.in_valid && bus.in_ready;

  // Length is compared one bit wider so a full 2**INST_ADDR_WIDTH load is legal.
  assign lenNext = {1'b0, bus.in_data, count[7:0]};
  assign lenBad  = (lenNext == '0) ||
                   (lenNext > ((LDR_LEN_W+1)'(1) << INST_ADDR_WIDTH));

  assign bus.inst_sram_wr   = wrStrobe;
  assign bus.inst_sram_addr = addr;
  assign bus.inst_sram_data = word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      byteIdx      <= '0;
      csum         <= '0;
      addr         <= '0;
      word         <= '0;
      wrStrobe     <= 1'b0;
      words_loaded <= '0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      core_hold    <= 1'b1;
    end else begin
      wrStrobe <= 1'b0;
      unique case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= LEN_LO;
            addr         <= '0;
            words_loaded <= '0;
            byteIdx      <= '0;
            csum         <= '0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            core_hold    <= 1'b1;
          end
        end
        LEN_LO: begin
          if (accept) begin
            count[7:0] <= bus.in_data;
            csum       <= csum ^ bus.in_data;
            state      <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept) begin
            count[15:8] <= bus.in_data;
            csum        <= csum ^ bus.in_data;
            if (lenBad) begin
              state    <= ERR;
              load_err <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            word[{byteIdx, 3'b000} +: 8] <= bus.in_data;
            csum    <= csum ^ bus.in_data;
            byteIdx <= byteIdx + 1'b1;
            if (byteIdx == IDX_W'(LDR_BYTES_PER_WORD - 1)) begin
              state    <= WRITE;
              wrStrobe <= 1'b1;
            end
          end
        end
        WRITE: begin
          addr         <= addr + INST_ADDR_WIDTH'(1);
          words_loaded <= words_loaded + LDR_LEN_W'(1);
          state        <= (words_loaded + LDR_LEN_W'(1) == count) ? CSUM : DATA;
        end
        CSUM: begin
          if (accept) begin
            if (bus.in_data == csum) begin
              state     <= DONE;
              load_done <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              state    <= ERR;
              load_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
